switch_conditioner: RTL

//  Input front-end for the irrigation controller: takes raw panel switches for sprinkler
//  (asp), drip (got) and fertilizer (adb), synchronises and debounces them. Resolves the

---
 rtl/switch_conditioner_if.sv | 37 +++
 rtl/switch_conditioner.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/switch_conditioner_if.sv
// Signal bundle between the irrigation panel front-end and the validation stage.
// Carries the sample enable, raw switches, conditioned outputs and FSM debug state;
// asp_rise exists only when SWITCH_EDGE_EN is defined.
interface switch_conditioner_if;
    logic       tick;
    logic       raw_asp;
    logic       raw_got;
    logic       raw_adb;
    logic       asp;
    logic       got;
    logic       adb;
    logic       conflict;
    logic [1:0] mode_state;
`ifdef SWITCH_EDGE_EN
    logic       asp_rise;

    modport master (
        output tick, raw_asp, raw_got, raw_adb,
        input  asp, got, adb, conflict, mode_state, asp_rise
    );

    modport slave (
        input  tick, raw_asp, raw_got, raw_adb,
        output asp, got, adb, conflict, mode_state, asp_rise
    );
`else
    modport master (
        output tick, raw_asp, raw_got, raw_adb,
        input  asp, got, adb, conflict, mode_state
    );

    modport slave (
        input  tick, raw_asp, raw_got, raw_adb,
        output asp, got, adb, conflict, mode_state
    );
`endif
endinterface

// File: rtl/switch_conditioner.sv
// Panel switch front-end: per-channel 2-FF synchroniser and tick-based debouncer, plus a
// sprinkler/drip mode FSM. Optional asp_rise pulse is built when SWITCH_EDGE_EN is defined.
module switch_conditioner #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    switch_conditioner_if.slave  sw
);

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_ASP   = 2'd1,
        M_GOT   = 2'd2,
        M_FAULT = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Channel order: 0 = sprinkler, 1 = drip, 2 = fertilizer.
    logic [2:0] raw;
    logic [2:0] stable;

    assign raw = {sw.raw_adb, sw.raw_got, sw.raw_asp};

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic             sync_meta;
        logic             sync_q;
        logic             stable_q;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_meta <= 1'b0;
                sync_q    <= 1'b0;
            end else begin
                sync_meta <= raw[ch];
                sync_q    <= sync_meta;
            end
        end

        // A differing level must be seen on DEBOUNCE_TICKS consecutive ticks; any
        // tick that sees agreement throws the partial count away.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                stable_q <= 1'b0;
                cnt      <= '0;
            end else if (sw.tick) begin
                if (sync_q == stable_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable_q <= sync_q;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end

        assign stable[ch] = stable_q;
    end

    logic  sa;
    logic  sg;
    mode_t state;
    mode_t next_state;

    assign sa = stable[0];
    assign sg = stable[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= M_OFF;
        end else begin
            state <= next_state;
        end
    end

    // FAULT only exits through OFF, so both switches must be released before reselecting.
    always_comb begin
        next_state = state;
        case (state)
            M_OFF: begin
                if (sa && !sg) begin
                    next_state = M_ASP;
                end else if (!sa && sg) begin
                    next_state = M_GOT;
                end else if (sa && sg) begin
                    next_state = M_FAULT;
                end
            end
            M_ASP: begin
                if (sg) begin
                    next_state = M_FAULT;
                end else if (!sa) begin
                    next_state = M_OFF;
                end
            end
            M_GOT: begin
                if (sa) begin
                    next_state = M_FAULT;
                end else if (!sg) begin
                    next_state = M_OFF;
                end
            end
            M_FAULT: begin
                if (!sa && !sg) begin
                    next_state = M_OFF;
                end
            end
            default: next_state = M_OFF;
        endcase
    end

    logic asp_q;
    logic got_q;
    logic conflict_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            asp_q      <= 1'b0;
            got_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            asp_q      <= (next_state == M_ASP);
            got_q      <= (next_state == M_GOT);
            conflict_q <= (next_state == M_FAULT);
        end
    end

    assign sw.asp        = asp_q;
    assign sw.got        = got_q;
    assign sw.conflict   = conflict_q;
    assign sw.adb        = stable[2];
    assign sw.mode_state = state;

`ifdef SWITCH_EDGE_EN
    logic asp_rise_q;

    // Registered alongside asp so the pulse lands on the same clock asp rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            asp_rise_q <= 1'b0;
        end else begin
            asp_rise_q <= (next_state == M_ASP) && (state != M_ASP);
        end
    end

    assign sw.asp_rise = asp_rise_q;
`endif

endmodule
